player_health_ctrl: RTL and testbench

- Downstream consumer of the per-enemy game logic instances. Collects every enemy's cumulative damage counter and kill score.
- Maintains the player's blood, hit-flash timer and total score.
- Runs the play / game-over / restart state machine.
- Drives a one-cycle restart request back to the enemy instances, the player block and the HUD.

---
 rtl/player_health_ctrl.sv | 132 +++++++++++++
 tb/tb_player_health_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/player_health_ctrl.sv
// Player blood, hit flash, score aggregation and play/game-over/restart FSM.
// Consumes cumulative per-enemy damage counters and kill counts.
module player_health_ctrl #(
  parameter int ENEMY_NUM         = 4,
  parameter int PLAYER_FULL_BLOOD = 100,
  parameter int FLASH_FRAMES      = 8,
  parameter int OVER_HOLD_FRAMES  = 120
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    game_frame_clk_rising_edge,
  input  logic [10*ENEMY_NUM-1:0] Enemy_Total_Damage_All,
  input  logic [10*ENEMY_NUM-1:0] Enemy_Score_All,
  input  logic                    Godmode_On,
  input  logic                    Restart,
  output logic [6:0]              Player_Blood,
  output logic                    Player_Hit_Flash,
  output logic [11:0]             Total_Score,
  output logic                    Game_Over,
  output logic [1:0]              Game_State,
  output logic                    Game_Reset_Req
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    GAME_OVER = 2'd1,
    RESTART   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     blood_q, blood_d;
  logic [FW-1:0]  flash_q, flash_d;
  logic [11:0]    score_q, score_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           req_q, req_d;
  logic [9:0]     prev_q [ENEMY_NUM];
  logic [9:0]     prev_d [ENEMY_NUM];
  logic [9:0]     delta  [ENEMY_NUM];
  logic [12:0]    d_sum;
  logic [11:0]    s_sum;
  logic           hit;

  // 10-bit subtraction makes a counter wrap look like a small positive step
  always_comb begin
    d_sum = '0;
    s_sum = '0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      delta[i]  = Enemy_Total_Damage_All[10*i +: 10] - prev_q[i];
      prev_d[i] = Enemy_Total_Damage_All[10*i +: 10];
      d_sum     = d_sum + 13'(delta[i]);
      s_sum     = s_sum + 12'(Enemy_Score_All[10*i +: 10]);
    end
    hit = (d_sum != '0) && !Godmode_On;
  end

  always_comb begin
    state_d = state_q;
    blood_d = blood_q;
    flash_d = flash_q;
    score_d = score_q;
    hold_d  = hold_q;
    if (game_frame_clk_rising_edge && flash_q != '0)
      flash_d = flash_q - FW'(1);
    unique case (state_q)
      PLAY: begin
        score_d = s_sum;
        hold_d  = '0;
        if (hit) begin
          if (d_sum >= {6'b0, blood_q})
            blood_d = '0;
          else
            blood_d = blood_q - d_sum[6:0];
          flash_d = FW'(FLASH_FRAMES);
        end
        if (blood_q == '0) begin
          state_d = GAME_OVER;
          flash_d = '0;
        end
      end
      GAME_OVER: begin
        flash_d = '0;
        if (game_frame_clk_rising_edge &&
            hold_q < HW'(OVER_HOLD_FRAMES))
          hold_d = hold_q + HW'(1);
        if (hold_q == HW'(OVER_HOLD_FRAMES) && Restart)
          state_d = RESTART;
      end
      RESTART: begin
        blood_d = 7'(PLAYER_FULL_BLOOD);
        score_d = '0;
        hold_d  = '0;
        flash_d = '0;
        state_d = PLAY;
      end
      default: state_d = PLAY;
    endcase
    req_d = (state_d == RESTART);
  end

  // enemy counters clear on the same edge that leaves RESTART
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= PLAY;
      blood_q <= 7'(PLAYER_FULL_BLOOD);
      flash_q <= '0;
      score_q <= '0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      for (int i = 0; i < ENEMY_NUM; i++) prev_q[i] <= '0;
    end else begin
      state_q <= state_d;
      blood_q <= blood_d;
      flash_q <= flash_d;
      score_q <= score_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      for (int i = 0; i < ENEMY_NUM; i++)
        prev_q[i] <= (state_q == RESTART) ? 10'd0 : prev_d[i];
    end
  end

  assign Player_Blood     = blood_q;
  assign Player_Hit_Flash = (flash_q != '0);
  assign Total_Score      = score_q;
  assign Game_Over        = (state_q == GAME_OVER);
  assign Game_State       = state_q;
  assign Game_Reset_Req   = req_q;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Directed bench for player_health_ctrl.
// Expected values are hand-computed per step.
module tb_player_health_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame;
  logic [39:0] dmg_all;
  logic [39:0] sc_all;
  logic        god;
  logic        restart;
  logic [6:0]  blood;
  logic        flash;
  logic [11:0] score;
  logic        over;
  logic [1:0]  state;
  logic        req;

  int n_pass = 0;
  int n_total = 0;

  player_health_ctrl dut (
    .Clk                        (Clk),
    .Reset                      (Reset),
    .game_frame_clk_rising_edge (frame),
    .Enemy_Total_Damage_All     (dmg_all),
    .Enemy_Score_All            (sc_all),
    .Godmode_On                 (god),
    .Restart                    (restart),
    .Player_Blood               (blood),
    .Player_Hit_Flash           (flash),
    .Total_Score                (score),
    .Game_Over                  (over),
    .Game_State                 (state),
    .Game_Reset_Req             (req)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic set_dmg(input int i, input logic [9:0] v);
    dmg_all[10*i +: 10] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_blood"}, 32'(blood), 32'd100);
    chk({tag, "_flash"}, 32'(flash), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_over"},  32'(over),  32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_req"},   32'(req),   32'd0);
  endtask

  initial begin
    Reset = 1'b1; frame = 1'b0; dmg_all = '0; sc_all = '0;
    god = 1'b0; restart = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk_reset_vals("rst");

    // single hit: 10 damage, flash lasts 8 frame pulses
    set_dmg(0, 10'd10);
    tick();
    chk("hit1_blood", 32'(blood), 32'd90);
    chk("hit1_flash", 32'(flash), 32'd1);
    tick();
    chk("hit1_hold", 32'(blood), 32'd90);
    for (int k = 1; k <= 8; k++) begin
      pulse();
      chk($sformatf("flash1_f%0d", k), 32'(flash), 32'(k < 8));
    end

    // two enemies same cycle, then reload at frame 5
    set_dmg(1, 10'd10);
    set_dmg(3, 10'd10);
    tick();
    chk("hit2_blood", 32'(blood), 32'd70);
    for (int k = 0; k < 5; k++) pulse();
    chk("hit2_f5", 32'(flash), 32'd1);
    set_dmg(0, 10'd15);
    tick();
    chk("hit3_blood", 32'(blood), 32'd65);
    for (int k = 1; k <= 8; k++) begin
      pulse();
      chk($sformatf("flash2_f%0d", k), 32'(flash), 32'(k < 8));
    end

    // godmode swallows the climb to 1020, then the wrap to 6
    god = 1'b1;
    set_dmg(2, 10'd1020);
    tick();
    chk("god1_blood", 32'(blood), 32'd65);
    chk("god1_flash", 32'(flash), 32'd0);
    god = 1'b0;
    set_dmg(2, 10'd6);
    tick();
    chk("wrap_blood", 32'(blood), 32'd55);
    chk("wrap_flash", 32'(flash), 32'd1);
    for (int k = 0; k < 8; k++) pulse();
    chk("wrap_fend", 32'(flash), 32'd0);
    god = 1'b1;
    set_dmg(0, 10'd65);
    tick();
    chk("god2_blood", 32'(blood), 32'd55);
    chk("god2_flash", 32'(flash), 32'd0);
    god = 1'b0;
    tick();
    chk("god2_after", 32'(blood), 32'd55);

    // score, then blood to 0 without underflow
    sc_all = {10'd1, 10'd2, 10'd0, 10'd3};
    tick();
    chk("score6", 32'(score), 32'd6);
    set_dmg(1, 10'd60);
    tick();
    chk("blood5", 32'(blood), 32'd5);
    set_dmg(3, 10'd20);
    tick();
    chk("blood0", 32'(blood), 32'd0);
    chk("over_not_yet", 32'(over), 32'd0);
    tick();
    chk("over1", 32'(over), 32'd1);
    chk("state_go", 32'(state), 32'd1);
    chk("go_flash", 32'(flash), 32'd0);
    sc_all = {10'd9, 10'd9, 10'd9, 10'd9};
    tick();
    chk("score_frozen", 32'(score), 32'd6);
    set_dmg(0, 10'd100);
    tick();
    chk("go_nodmg", 32'(blood), 32'd0);

    // restart only honoured once the hold expires
    for (int k = 0; k < 50; k++) pulse();
    restart = 1'b1;
    tick(); tick(); tick();
    chk("early_restart", 32'(state), 32'd1);
    for (int k = 0; k < 69; k++) pulse();
    chk("f119_state", 32'(state), 32'd1);
    pulse();
    chk("f120_state", 32'(state), 32'd1);
    chk("f120_req", 32'(req), 32'd0);
    tick();
    chk("rs_state", 32'(state), 32'd2);
    chk("rs_req", 32'(req), 32'd1);
    dmg_all = '0;
    sc_all = '0;
    restart = 1'b0;
    tick();
    chk_reset_vals("post_rs");
    tick();
    chk("post_rs2_blood", 32'(blood), 32'd100);
    chk("post_rs2_req", 32'(req), 32'd0);

    // reset while in GAME_OVER
    set_dmg(0, 10'd200);
    tick();
    chk("kill_blood", 32'(blood), 32'd0);
    tick();
    chk("kill_state", 32'(state), 32'd1);
    chk("kill_flash", 32'(flash), 32'd0);
    dmg_all = '0;
    Reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    Reset = 1'b0;
    tick();
    chk("mid_rst_after", 32'(blood), 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
